// File: rtl/exec_unit.sv
// Execute stage between the register-file read ports and its write port.
// ALU ops finish in one cycle; variable shifts and 8x8 multiply iterate and hold busy.
module exec_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    output logic              busy,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_val,
    output logic              carry,
    output logic              zero,
    output logic [1:0]        dbg_state
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_MOV = 3'd4;
    localparam logic [2:0] OP_LSL = 3'd5;
    localparam logic [2:0] OP_LSR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  dir_q, dir_d;
    logic [ADDR_W-1:0]     dst_q, dst_d;
    logic [DATA_W-1:0]     work_q, work_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [2*DATA_W-1:0]   mcand_q, mcand_d;
    logic                  wb_en_q, wb_en_d;
    logic [ADDR_W-1:0]     wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]     wb_val_q, wb_val_d;
    logic                  carry_q, carry_d;
    logic                  zero_q, zero_d;

    logic [DATA_W:0]       sum;
    logic [DATA_W-1:0]     res;
    logic                  res_c;
    logic                  single;
    logic [DATA_W-1:0]     sh_nx;
    logic                  sh_out;
    logic [2*DATA_W-1:0]   acc_nx;

    // Handshake: start is the valid, !busy is the ready; an op transfers only when both are high.
    assign busy      = (state_q != ST_IDLE);
    assign wb_en     = wb_en_q;
    assign wb_addr   = wb_addr_q;
    assign wb_val    = wb_val_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        dst_d     = dst_q;
        work_d    = work_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_val_d  = wb_val_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        sum       = '0;
        res       = '0;
        res_c     = 1'b0;
        single    = 1'b0;

        // One iteration of the shifter (dir_q=1 is right) and of the shift-add multiplier.
        if (dir_q) begin
            sh_nx  = {1'b0, work_q[DATA_W-1:1]};
            sh_out = work_q[0];
        end else begin
            sh_nx  = {work_q[DATA_W-2:0], 1'b0};
            sh_out = work_q[DATA_W-1];
        end
        acc_nx = acc_q + (work_q[0] ? mcand_q : '0);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dst_d  = dst;
                    single = 1'b1;
                    case (op)
                        OP_ADD: begin
                            sum   = {1'b0, src_a} + {1'b0, src_b};
                            res   = sum[DATA_W-1:0];
                            res_c = sum[DATA_W];
                        end
                        OP_SUB: begin
                            res   = src_a - src_b;
                            res_c = (src_a >= src_b);
                        end
                        OP_AND: res = src_a & src_b;
                        OP_XOR: res = src_a ^ src_b;
                        OP_MOV: res = src_b;
                        OP_LSL, OP_LSR: begin
                            res = src_a;
                            if (src_b[2:0] != 3'd0) begin
                                single  = 1'b0;
                                state_d = ST_SHIFT;
                                cnt_d   = {1'b0, src_b[2:0]};
                                dir_d   = (op == OP_LSR);
                                work_d  = src_a;
                            end
                        end
                        OP_MUL: begin
                            single  = 1'b0;
                            state_d = ST_MUL;
                            cnt_d   = 4'(DATA_W);
                            work_d  = src_b;
                            mcand_d = {{DATA_W{1'b0}}, src_a};
                            acc_d   = '0;
                        end
                        default: ;
                    endcase
                    if (single) begin
                        wb_en_d   = 1'b1;
                        wb_addr_d = dst;
                        wb_val_d  = res;
                        carry_d   = res_c;
                        zero_d    = (res == '0);
                    end
                end
            end
            ST_SHIFT: begin
                work_d = sh_nx;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = ST_IDLE;
                    wb_en_d   = 1'b1;
                    wb_addr_d = dst_q;
                    wb_val_d  = sh_nx;
                    carry_d   = sh_out;
                    zero_d    = (sh_nx == '0);
                end
            end
            ST_MUL: begin
                acc_d   = acc_nx;
                mcand_d = mcand_q << 1;
                work_d  = work_q >> 1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = ST_IDLE;
                    wb_en_d   = 1'b1;
                    wb_addr_d = dst_q;
                    wb_val_d  = acc_nx[DATA_W-1:0];
                    carry_d   = |acc_nx[2*DATA_W-1:DATA_W];
                    zero_d    = (acc_nx[DATA_W-1:0] == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            dst_q     <= '0;
            work_q    <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_val_q  <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            dst_q     <= dst_d;
            work_q    <= work_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_val_q  <= wb_val_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage sitting directly downstream of the 16-entry register file.
- Consumes the two read-port values and produces the write-back triple (value, enable, address) that feeds the register file write port.
- Single-cycle ALU ops complete in one cycle.
- Variable shifts and 8x8 multiply are iterative and hold the stage busy until they write back.

Parameters:
DATA_W, 8, operand/result width
ADDR_W, 4, register address width (16 registers)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  issue strobe; op/src_a/src_b/dst valid this cycle
op  input  3  000 ADD, 001 SUB, 010 AND, 011 XOR, 100 MOV, 101 LSL, 110 LSR, 111 MUL
src_a  input  DATA_W  operand A (register file read port 1)
src_b  input  DATA_W  operand B (register file read port 2)
dst  input  ADDR_W  destination register address
busy  output  1  multi-cycle op in progress; start ignored while high
wb_en  output  1  one-cycle write-back pulse to register file write enable
wb_addr  output  ADDR_W  write-back register address
wb_val  output  DATA_W  write-back value
carry  output  1  carry flag, updated only on wb_en
zero  output  1  zero flag (wb_val==0), updated only on wb_en

Behaviour:
- Reset (reset==0, asynchronous):
  - FSM to IDLE.
  - busy, wb_en, wb_addr, wb_val, carry and zero all go to 0.
  - Any in-flight op is aborted and never writes back.
- FSM states: IDLE, SHIFT, MUL.
- Issue rule: start is accepted only when busy==0. This includes the cycle in which wb_en pulses.
- On acceptance, op, src_a, src_b and dst are captured. Register-file changes after the issue cycle do not affect the result.
- Single-cycle ops (ADD/SUB/AND/XOR/MOV), and LSL/LSR with src_b[2:0]==0:
  - start at cycle 0 -> wb_en=1 at cycle 1, with registered wb_addr/wb_val/flags.
  - FSM stays in IDLE.
  - Throughput is one op per cycle.
- LSL/LSR with n=src_b[2:0]>0:
  - IDLE->SHIFT.
  - busy=1 during cycles 1..n.
  - One bit shifted per cycle, zero fill.
  - wb_en at cycle n+1, and busy drops to 0 that same cycle; SHIFT->IDLE.
  - src_b[7:3] is ignored.
- MUL:
  - IDLE->MUL.
  - Shift-add over 8 iterations: one multiplier bit per cycle, LSB first, 16-bit accumulator.
  - busy=1 for cycles 1..8.
  - wb_en at cycle 9, with wb_val = product[7:0]; MUL->IDLE.
- Result rules (8-bit, wrap-around):
  - ADD: a+b mod 256; carry = bit 8.
  - SUB: a-b mod 256; carry = 1 iff a>=b (no borrow).
  - AND/XOR: bitwise; carry=0.
  - MOV: wb_val=b; carry=0.
  - LSL/LSR: carry = last bit shifted out; for n=0, carry=0.
  - MUL: carry = 1 iff product[15:8]!=0.
- Between pulses: wb_en=0. wb_addr, wb_val, carry and zero hold their last write-back values.
- start with busy==1: ignored completely, no queuing and no effect on the in-flight op.
- dst is passed through unmodified. No forwarding is done inside this block.

Test Plan:
1. Reset low for 2 cycles, then release -> all outputs 0. Then ADD a=200 b=100 dst=3 at cycle 0 -> cycle 1: wb_en=1, wb_addr=3, wb_val=44, carry=1, zero=0; cycle 2: wb_en=0, wb_val holds 44.
2. SUB a=5 b=5 dst=7 -> cycle 1: wb_val=0, zero=1, carry=1. Then SUB a=3 b=5 -> wb_val=254, carry=0, zero=0.
3. Back-to-back: ADD a=1 b=2 dst=1 at cycle 0, XOR a=0xFF b=0x0F dst=2 at cycle 1 -> wb_en pulses at cycles 1 and 2 with (1,3) and (2,0xF0); busy stays 0.
4. LSL a=0x81 b=3 dst=4 -> busy=1 at cycles 1-3, wb_en at cycle 4, wb_val=0x08, carry=0. Also LSR a=0x81 b=1 -> wb at cycle 2, wb_val=0x40, carry=1.
5. MUL a=13 b=20 dst=9 at cycle 0, plus ADD start at cycle 4 -> ADD ignored; single wb_en at cycle 9 with wb_addr=9, wb_val=0x04, carry=1. A new start at cycle 9 is accepted.
6. MUL a=15 b=15 at cycle 0, reset low at cycle 4 for 1 cycle -> outputs 0 immediately and no wb_en for the MUL. After release, MOV b=0x5A dst=12 -> wb_val=0x5A at the next cycle.
